// File: rtl/fork_join_pkg.sv
// Shared types and helpers for the fork/join scheduler.
//   join_mode_e  : completion condition selected per fork
//   ctrl_state_e : controller FSM states
//   lowest_set_idx(): index of the lowest set bit of a worker vector
package fork_join_pkg;

  localparam int unsigned MAX_WORKERS = 16;
  localparam int unsigned IDX_W       = 4;

  typedef enum logic [1:0] {
    JOIN_ALL  = 2'd0,
    JOIN_ANY  = 2'd1,
    JOIN_NONE = 2'd2
  } join_mode_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    JOIN   = 2'd3
  } ctrl_state_e;

  // Returns 0 for an all-zero vector.
  function automatic logic [IDX_W-1:0] lowest_set_idx(input logic [MAX_WORKERS-1:0] v);
    logic [IDX_W-1:0] idx;
    logic             found;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < MAX_WORKERS; i++) begin
      if (v[i] && !found) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/done_tracker.sv
// Outstanding-worker register bank.
//   clk, rst : clock, synchronous active-high reset
//   set_i    : workers being launched this cycle (set wins over clear)
//   clr_i    : worker done pulses
//   out_o    : workers launched and not yet done
module done_tracker #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] set_i,
  input  logic [W-1:0] clr_i,
  output logic [W-1:0] out_o
);

  logic [W-1:0] out_q, out_d;

  // A done in the same cycle as its start is ignored because set dominates.
  always_comb begin
    out_d = (out_q & ~clr_i) | set_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign out_o = out_q;

endmodule

// File: rtl/fork_join_ctrl.sv
// Fork/join scheduler: launches a group of workers on one fork request and
// pulses join when JOIN_ALL / JOIN_ANY / JOIN_NONE completes or times out.
//   fork_valid/fork_ready/fork_mask/fork_mode : fork request handshake
//   wkr_start / wkr_done                      : per-worker start/done pulses
//   join_valid, join_mask, first_id,
//   join_timeout, join_err                    : one-cycle join report
//   outstanding                               : launched workers not yet done
module fork_join_ctrl
  import fork_join_pkg::*;
#(
  parameter int unsigned N_WORKERS   = 4,
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fork_valid,
  output logic                 fork_ready,
  input  logic [N_WORKERS-1:0] fork_mask,
  input  logic [1:0]           fork_mode,
  output logic [N_WORKERS-1:0] wkr_start,
  input  logic [N_WORKERS-1:0] wkr_done,
  output logic                 join_valid,
  output logic [N_WORKERS-1:0] join_mask,
  output logic [((N_WORKERS > 1) ? $clog2(N_WORKERS) : 1)-1:0] first_id,
  output logic                 join_timeout,
  output logic                 join_err,
  output logic [N_WORKERS-1:0] outstanding
);

  localparam int unsigned W     = N_WORKERS;
  localparam int unsigned ID_W  = (N_WORKERS > 1) ? $clog2(N_WORKERS) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic             TO_EN   = (TIMEOUT_CYC != 0);

  ctrl_state_e      state_q, state_d;
  join_mode_e       mode_q, mode_d;
  logic [W-1:0]     mask_q, mask_d;
  logic [W-1:0]     completed_q, completed_d;
  logic [ID_W-1:0]  fid_q, fid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ready_q, ready_d;
  logic [W-1:0]     start_q, start_d;
  logic             jvalid_q, jvalid_d;
  logic [W-1:0]     jmask_q, jmask_d;
  logic [ID_W-1:0]  jfid_q, jfid_d;
  logic             jto_q, jto_d;
  logic             jerr_q, jerr_d;

  logic [W-1:0]     trk_set;
  logic [W-1:0]     new_done;
  logic [W-1:0]     comp_nx;
  logic [ID_W-1:0]  fid_nx;
  logic             met;

  done_tracker #(.W(W)) u_tracker (
    .clk   (clk),
    .rst   (rst),
    .set_i (trk_set),
    .clr_i (wkr_done),
    .out_o (outstanding)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    mask_d      = mask_q;
    completed_d = completed_q;
    fid_d       = fid_q;
    cnt_d       = cnt_q;
    start_d     = '0;
    jvalid_d    = 1'b0;
    jmask_d     = '0;
    jfid_d      = '0;
    jto_d       = 1'b0;
    jerr_d      = 1'b0;
    trk_set     = '0;

    // Only dones of still-outstanding group members count as completions.
    new_done = mask_q & wkr_done & outstanding;
    comp_nx  = completed_q | new_done;
    fid_nx   = (completed_q == '0 && new_done != '0)
               ? ID_W'(lowest_set_idx(MAX_WORKERS'(new_done))) : fid_q;
    met      = (mode_q == JOIN_ANY) ? (comp_nx != '0) : (comp_nx == mask_q);

    case (state_q)
      IDLE: begin
        if (fork_valid) begin
          mask_d      = fork_mask;
          mode_d      = (fork_mode == 2'd3) ? JOIN_ALL : join_mode_e'(fork_mode);
          completed_d = '0;
          fid_d       = '0;
          if ((fork_mask & outstanding) != '0) begin
            state_d  = JOIN;
            jvalid_d = 1'b1;
            jerr_d   = 1'b1;
          end else if (fork_mask == '0) begin
            state_d  = JOIN;
            jvalid_d = 1'b1;
          end else begin
            state_d = LAUNCH;
            start_d = fork_mask;
          end
        end
      end
      LAUNCH: begin
        trk_set = mask_q;
        cnt_d   = '0;
        if (mode_q == JOIN_NONE) begin
          state_d  = JOIN;
          jvalid_d = 1'b1;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        completed_d = comp_nx;
        fid_d       = fid_nx;
        cnt_d       = cnt_q + CNT_W'(1);
        // A condition met on the last counted cycle wins over the timeout.
        if (met || (TO_EN && cnt_q == TO_LAST)) begin
          state_d  = JOIN;
          jvalid_d = 1'b1;
          jmask_d  = comp_nx;
          jfid_d   = (comp_nx == '0) ? '0 : fid_nx;
          jto_d    = !met;
        end
      end
      JOIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mode_q      <= JOIN_ALL;
      mask_q      <= '0;
      completed_q <= '0;
      fid_q       <= '0;
      cnt_q       <= '0;
      ready_q     <= 1'b1;
      start_q     <= '0;
      jvalid_q    <= 1'b0;
      jmask_q     <= '0;
      jfid_q      <= '0;
      jto_q       <= 1'b0;
      jerr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      mask_q      <= mask_d;
      completed_q <= completed_d;
      fid_q       <= fid_d;
      cnt_q       <= cnt_d;
      ready_q     <= ready_d;
      start_q     <= start_d;
      jvalid_q    <= jvalid_d;
      jmask_q     <= jmask_d;
      jfid_q      <= jfid_d;
      jto_q       <= jto_d;
      jerr_q      <= jerr_d;
    end
  end

  assign fork_ready   = ready_q;
  assign wkr_start    = start_q;
  assign join_valid   = jvalid_q;
  assign join_mask    = jmask_q;
  assign first_id     = jfid_q;
  assign join_timeout = jto_q;
  assign join_err     = jerr_q;

endmodule

// File: tb/tb_fork_join_ctrl.sv
// Bench for fork_join_ctrl: timestamp-based reference model compared every
// cycle, directed forks with simple latency-driven workers, and literal checks.
module tb_fork_join_ctrl;

  localparam int TO = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fork_valid = 1'b0;
  logic       fork_ready;
  logic [3:0] fork_mask = '0;
  logic [1:0] fork_mode = '0;
  logic [3:0] wkr_start;
  logic [3:0] wkr_done = '0;
  logic       join_valid;
  logic [3:0] join_mask;
  logic [1:0] first_id;
  logic       join_timeout;
  logic       join_err;
  logic [3:0] outstanding;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  fork_join_ctrl #(.N_WORKERS(4), .TIMEOUT_CYC(TO), .CNT_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .fork_valid   (fork_valid),
    .fork_ready   (fork_ready),
    .fork_mask    (fork_mask),
    .fork_mode    (fork_mode),
    .wkr_start    (wkr_start),
    .wkr_done     (wkr_done),
    .join_valid   (join_valid),
    .join_mask    (join_mask),
    .first_id     (first_id),
    .join_timeout (join_timeout),
    .join_err     (join_err),
    .outstanding  (outstanding)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cyc %0d: got %0h, want %0h", nm, cyc, act, exp);
    end
  endtask

  // ---------------- reference model (expected outputs for the next cycle)
  logic [3:0] m_outs = '0, m_mask = '0, m_got = '0, m_news, m_nxt;
  int         m_mode = 0, m_first = 0, m_launch_c = -1, m_wait_c = 0;
  int         m_ready_at = 0;
  bit         m_waiting = 0, m_met;
  int         c;
  logic       e_ready = 1'b1, e_jv = 1'b0, e_to = 1'b0, e_err = 1'b0;
  logic [3:0] e_start = '0, e_jm = '0, e_outs = '0;
  int         e_fid = 0;

  always @(posedge clk) begin
    c = cyc;
    e_start = '0; e_jv = 1'b0; e_jm = '0; e_fid = 0; e_to = 1'b0; e_err = 1'b0;
    if (rst) begin
      m_outs = '0; m_launch_c = -1; m_waiting = 0; m_ready_at = 0;
      e_ready = 1'b1;
    end else begin
      m_news = m_waiting ? (m_mask & wkr_done & m_outs) : 4'b0000;
      m_nxt  = m_outs & ~wkr_done;
      if (c == m_launch_c) begin
        m_nxt = m_nxt | m_mask;
        m_launch_c = -1;
        if (m_mode == 2) begin
          e_jv = 1'b1; m_ready_at = c + 2;
        end else begin
          m_waiting = 1; m_wait_c = c + 1; m_got = '0; m_first = 0;
        end
      end else if (m_waiting) begin
        if (m_got == 4'b0000 && m_news != 4'b0000) begin
          m_first = 0;
          while (m_news[m_first] == 1'b0) m_first++;
        end
        m_got = m_got | m_news;
        m_met = (m_mode == 1) ? (m_got != 4'b0000) : (m_got == m_mask);
        if (m_met || (c - m_wait_c == TO - 1)) begin
          e_jv = 1'b1; e_jm = m_got; e_fid = (m_got == 4'b0000) ? 0 : m_first;
          e_to = !m_met; m_waiting = 0; m_ready_at = c + 2;
        end
      end else if (c >= m_ready_at && fork_valid) begin
        if ((fork_mask & m_outs) != 4'b0000) begin
          e_jv = 1'b1; e_err = 1'b1; m_ready_at = c + 2;
        end else if (fork_mask == 4'b0000) begin
          e_jv = 1'b1; m_ready_at = c + 2;
        end else begin
          e_start = fork_mask; m_mask = fork_mask;
          m_mode = (fork_mode == 2'd3) ? 0 : int'(fork_mode);
          m_launch_c = c + 1; m_ready_at = 32'h7fffffff;
        end
      end
      m_outs  = m_nxt;
      e_ready = (c + 1 >= m_ready_at) && !m_waiting && (m_launch_c < 0);
    end
    e_outs = m_outs;
    cyc = cyc + 1;
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (cyc >= 1) begin
      chk("fork_ready",   32'(fork_ready),   32'(e_ready));
      chk("wkr_start",    32'(wkr_start),    32'(e_start));
      chk("join_valid",   32'(join_valid),   32'(e_jv));
      chk("join_mask",    32'(join_mask),    32'(e_jm));
      chk("first_id",     32'(first_id),     32'(e_fid));
      chk("join_timeout", 32'(join_timeout), 32'(e_to));
      chk("join_err",     32'(join_err),     32'(e_err));
      chk("outstanding",  32'(outstanding),  32'(e_outs));
    end
  end

  // ---------------- worker responders: done pulse lat[w] cycles after start
  int lat [4] = '{10, 10, 10, 10};
  int due [4] = '{-1, -1, -1, -1};

  always @(negedge clk) begin
    for (int w = 0; w < 4; w++) begin
      if (wkr_start[w] === 1'b1) due[w] = (lat[w] < 0) ? -1 : cyc + lat[w];
      wkr_done[w] = (due[w] == cyc);
    end
  end

  // ---------------- stimulus helpers
  task automatic do_fork(input logic [3:0] mk, input logic [1:0] md, output int acc);
    int n;
    n = 0;
    while (fork_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (fork_ready !== 1'b1) begin
      total++; bad++;
      $display("FAIL fork_ready_wait at cyc %0d: got %0b, want 1", cyc, fork_ready);
    end
    fork_valid = 1'b1; fork_mask = mk; fork_mode = md; acc = cyc;
    @(negedge clk);
    fork_valid = 1'b0; fork_mask = '0; fork_mode = '0;
  endtask

  task automatic wait_join(input int budget, output int jc);
    jc = -1;
    for (int i = 0; i < budget; i++) begin
      if (join_valid === 1'b1) begin
        jc = cyc;
        break;
      end
      @(negedge clk);
    end
    if (jc < 0) begin
      total++; bad++;
      $display("FAIL join_wait at cyc %0d: got no join, want join within %0d", cyc, budget);
    end
  endtask

  task automatic wait_idle_outs(input int budget, output int oc);
    oc = -1;
    for (int i = 0; i < budget; i++) begin
      if (outstanding === 4'b0000) begin
        oc = cyc;
        break;
      end
      @(negedge clk);
    end
    if (oc < 0) begin
      total++; bad++;
      $display("FAIL drain_wait at cyc %0d: got %04b, want 0000", cyc, outstanding);
    end
  endtask

  // ---------------- directed sequence
  initial begin
    int t, t2, jc, oc;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(fork_ready), 32'd1);
    chk("rst_outs",  32'(outstanding), 32'd0);
    chk("rst_jv",    32'(join_valid), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // JOIN_ANY, mask 0011, latencies 20/30
    lat[0] = 20; lat[1] = 30;
    do_fork(4'b0011, 2'd1, t);
    chk("t1_start", 32'(wkr_start), 32'h3);
    wait_join(60, jc);
    chk("t1_join_cyc", 32'(jc - t), 32'd22);
    chk("t1_mask", 32'(join_mask), 32'h1);
    chk("t1_fid",  32'(first_id), 32'd0);
    chk("t1_outs", 32'(outstanding), 32'h2);
    wait_idle_outs(60, oc);
    chk("t1_drain_cyc", 32'(oc - t), 32'd32);

    // JOIN_ALL, same mask and latencies
    do_fork(4'b0011, 2'd0, t);
    wait_join(60, jc);
    chk("t2_join_cyc", 32'(jc - t), 32'd32);
    chk("t2_mask", 32'(join_mask), 32'h3);
    chk("t2_fid",  32'(first_id), 32'd0);
    chk("t2_to",   32'(join_timeout), 32'd0);
    @(negedge clk);

    // JOIN_NONE, mask 1100, then colliding fork 0100
    lat[2] = 40; lat[3] = 10;
    do_fork(4'b1100, 2'd2, t);
    chk("t3_start", 32'(wkr_start), 32'hc);
    wait_join(5, jc);
    chk("t3_join_cyc", 32'(jc - t), 32'd2);
    chk("t3_mask", 32'(join_mask), 32'h0);
    do_fork(4'b0100, 2'd0, t2);
    wait_join(5, jc);
    chk("t3_err_cyc", 32'(jc - t2), 32'd1);
    chk("t3_err",     32'(join_err), 32'd1);
    chk("t3_err_mask", 32'(join_mask), 32'h0);
    chk("t3_err_nostart", 32'(wkr_start), 32'h0);
    chk("t3_err_outs", 32'(outstanding), 32'hc);
    wait_idle_outs(80, oc);
    chk("t3_drain_cyc", 32'(oc - t), 32'd42);

    // JOIN_ANY, w1 and w3 done together
    lat[1] = 15; lat[3] = 15;
    do_fork(4'b1010, 2'd1, t);
    wait_join(40, jc);
    chk("t4_join_cyc", 32'(jc - t), 32'd17);
    chk("t4_mask", 32'(join_mask), 32'ha);
    chk("t4_fid",  32'(first_id), 32'd1);
    chk("t4_outs", 32'(outstanding), 32'h0);

    // Empty mask
    do_fork(4'b0000, 2'd1, t);
    chk("t5_jv",   32'(join_valid), 32'd1);
    chk("t5_err",  32'(join_err), 32'd0);
    chk("t5_mask", 32'(join_mask), 32'h0);

    // Reserved mode behaves as JOIN_ALL
    lat[2] = 5;
    do_fork(4'b0100, 2'd3, t);
    wait_join(20, jc);
    chk("t6_join_cyc", 32'(jc - t), 32'd7);
    chk("t6_mask", 32'(join_mask), 32'h4);
    chk("t6_fid",  32'(first_id), 32'd2);

    // Timeout: worker 0 never finishes
    lat[0] = -1;
    do_fork(4'b0001, 2'd0, t);
    wait_join(150, jc);
    chk("t7_join_cyc", 32'(jc - t), 32'd102);
    chk("t7_to",   32'(join_timeout), 32'd1);
    chk("t7_mask", 32'(join_mask), 32'h0);
    chk("t7_fid",  32'(first_id), 32'd0);
    repeat (5) @(negedge clk);
    chk("t7_outs_held", 32'(outstanding), 32'h1);

    // Reset during WAIT, then a stale done pulse
    lat[1] = 50;
    do_fork(4'b0010, 2'd0, t);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t8_ready", 32'(fork_ready), 32'd1);
    chk("t8_outs",  32'(outstanding), 32'h0);
    chk("t8_jv",    32'(join_valid), 32'd0);
    chk("t8_start", 32'(wkr_start), 32'h0);
    repeat (50) @(negedge clk);
    chk("t8_stale_outs", 32'(outstanding), 32'h0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog at cyc %0d: got no end, want finish", cyc);
    $fatal(1);
  end

endmodule
